// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO pointer/flag stages.
// A package cannot be parameterised, so these are defaults; width-dependent values use depth_of().
package fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 9;
  localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH_DEF;
  localparam int unsigned AF_THRESH_DEF  = DEPTH - 4;
  localparam int unsigned AE_THRESH_DEF  = 4;

  // Pointer at the default width: ADDR_WIDTH address bits plus one wrap bit.
  typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/fifo_pointer_control_if.sv
// Handshake, pointer and status bundle between producer/consumer, flag control and pointer control.
interface fifo_pointer_control_if #(
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH_DEF
);

    logic                WrReq;
    logic                RdReq;
    logic                ClrErr;
    logic                Full;
    logic                Empty;
    logic [ADDR_WIDTH:0] WriteAddr;
    logic [ADDR_WIDTH:0] ReadAddr;
    logic                WrEn;
    logic                RdEn;
    logic                RdValid;
    logic [ADDR_WIDTH:0] Count;
    logic                AlmostFull;
    logic                AlmostEmpty;
    logic                Overflow;
    logic                Underflow;

    // Requester / flag-control side.
    modport master (
        output WrReq, RdReq, ClrErr, Full, Empty,
        input  WriteAddr, ReadAddr, WrEn, RdEn, RdValid, Count,
        input  AlmostFull, AlmostEmpty, Overflow, Underflow
    );

    // Pointer-control side.
    modport slave (
        input  WrReq, RdReq, ClrErr, Full, Empty,
        output WriteAddr, ReadAddr, WrEn, RdEn, RdValid, Count,
        output AlmostFull, AlmostEmpty, Overflow, Underflow
    );

endinterface

// File: rtl/fifo_ptr_counter.sv
// Wrap-around pointer counter with enable and synchronous reset.
// The top bit is the wrap bit; it toggles naturally when the address bits roll over.
module fifo_ptr_counter #(
    parameter int unsigned WIDTH = fifo_pkg::ADDR_WIDTH_DEF + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (en) begin
            value_d = value_q + One;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fifo_pointer_control.sv
// FIFO pointer and handshake stage: qualifies requests against Full/Empty, owns both pointers,
// and keeps fill level, registered threshold flags, read-valid timing and sticky error flags.
module fifo_pointer_control
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned AF_THRESH  = 2 ** ADDR_WIDTH - 4,
    parameter int unsigned AE_THRESH  = AE_THRESH_DEF
) (
    input logic                   clk,
    input logic                   rst,
    fifo_pointer_control_if.slave bus
);

    typedef logic [ADDR_WIDTH:0] cnt_t;

    localparam cnt_t CntOne   = cnt_t'(1);
    localparam cnt_t AfThresh = cnt_t'(AF_THRESH);
    localparam cnt_t AeThresh = cnt_t'(AE_THRESH);

    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= depth_of(ADDR_WIDTH))) begin : g_bad_thresh
        $error("fifo_pointer_control: need 0 <= AE_THRESH < AF_THRESH <= 2**ADDR_WIDTH");
    end

    logic wr_en;
    logic rd_en;

    cnt_t count_q, count_d;
    logic rd_valid_q;
    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Full/Empty come from the registered pointers, so these strobes never form a loop.
    assign wr_en = bus.WrReq & ~bus.Full & ~rst;
    assign rd_en = bus.RdReq & ~bus.Empty & ~rst;

    fifo_ptr_counter #(
        .WIDTH (ADDR_WIDTH + 1)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en    (wr_en),
        .value (bus.WriteAddr)
    );

    fifo_ptr_counter #(
        .WIDTH (ADDR_WIDTH + 1)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en    (rd_en),
        .value (bus.ReadAddr)
    );

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Thresholds are taken on the next count so the registered flags line up with Count.
    always_comb begin
        almost_full_d  = (count_d >= AfThresh);
        almost_empty_d = (count_d <= AeThresh);
    end

    // A set condition in the same cycle beats ClrErr.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.ClrErr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.WrReq && bus.Full) begin
            overflow_d = 1'b1;
        end
        if (bus.RdReq && bus.Empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q        <= '0;
            rd_valid_q     <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            count_q        <= count_d;
            rd_valid_q     <= rd_en;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign bus.WrEn        = wr_en;
    assign bus.RdEn        = rd_en;
    assign bus.RdValid     = rd_valid_q;
    assign bus.Count       = count_q;
    assign bus.AlmostFull  = almost_full_q;
    assign bus.AlmostEmpty = almost_empty_q;
    assign bus.Overflow    = overflow_q;
    assign bus.Underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_pointer_control.sv
// Bench for fifo_pointer_control at depth 4: directed scenarios plus random traffic,
// checked against a queue-based occupancy model.
module tb_fifo_pointer_control;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 1;
    localparam int          PMOD  = 8;

    typedef logic [AW:0] ptr_t;

    logic clk;
    logic rst;

    fifo_pointer_control_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_pointer_control #(
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Flag-control stage: full when addresses match but wrap bits differ.
    assign bus.Full  = (bus.WriteAddr[AW] != bus.ReadAddr[AW]) &&
                       (bus.WriteAddr[AW-1:0] == bus.ReadAddr[AW-1:0]);
    assign bus.Empty = (bus.WriteAddr == bus.ReadAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of stored slot numbers, plus total-op pointers.
    int   m_q[$];
    int   m_wr  = 0;
    int   m_rd  = 0;
    logic m_rdv = 1'b0;
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
    logic m_af  = 1'b0;
    logic m_ae  = 1'b1;
    logic m_full, m_empty, m_wren, m_rden;

    task automatic drive(input logic wr, input logic rd, input logic clr, input logic r);
        @(negedge clk);
        bus.WrReq  = wr;
        bus.RdReq  = rd;
        bus.ClrErr = clr;
        rst        = r;
        #1;
        m_full  = (m_q.size() == DEPTH);
        m_empty = (m_q.size() == 0);
        m_wren  = wr && !m_full && !r;
        m_rden  = rd && !m_empty && !r;
    endtask

    task automatic tick();
        if (rst) begin
            m_q.delete();
            m_wr  = 0;
            m_rd  = 0;
            m_rdv = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (m_rden) begin
                void'(m_q.pop_front());
                m_rd = (m_rd + 1) % PMOD;
            end
            if (m_wren) begin
                m_q.push_back(m_wr);
                m_wr = (m_wr + 1) % PMOD;
            end
            m_rdv = m_rden;
            if (bus.WrReq && m_full) m_ovf = 1'b1;
            else if (bus.ClrErr)     m_ovf = 1'b0;
            if (bus.RdReq && m_empty) m_udf = 1'b1;
            else if (bus.ClrErr)      m_udf = 1'b0;
        end
        m_af = (m_q.size() >= AF);
        m_ae = (m_q.size() <= AE);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (bus.WrEn !== 1'b0 || bus.RdEn !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: WrEn=%b RdEn=%b required 0 0", bus.WrEn, bus.RdEn);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.WriteAddr, bus.ReadAddr, bus.Count} !== {ptr_t'(0), ptr_t'(0), ptr_t'(0)}) begin
            n_fail++;
            $display("FAIL reset_ptrs: wa=%0d ra=%0d cnt=%0d required 0 0 0",
                     bus.WriteAddr, bus.ReadAddr, bus.Count);
        end
        n_checks++;
        if ({bus.RdValid, bus.AlmostFull, bus.AlmostEmpty, bus.Overflow, bus.Underflow}
            !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_flags: rv/af/ae/ov/un=%b%b%b%b%b required 00100", bus.RdValid,
                     bus.AlmostFull, bus.AlmostEmpty, bus.Overflow, bus.Underflow);
        end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (bus.WrEn !== 1'b1 || bus.WriteAddr !== ptr_t'(i)) begin
                n_fail++;
                $display("FAIL fill_wr%0d: WrEn=%b wa=%0d required 1 %0d", i, bus.WrEn,
                         bus.WriteAddr, i);
            end
            n_checks++;
            if (bus.Count !== ptr_t'(m_q.size()) || bus.AlmostFull !== m_af) begin
                n_fail++;
                $display("FAIL fill_cnt%0d: cnt=%0d af=%b required %0d %b", i, bus.Count,
                         bus.AlmostFull, m_q.size(), m_af);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.WriteAddr !== 3'b100 || bus.Count !== ptr_t'(4) || bus.Full !== 1'b1 ||
            bus.AlmostFull !== 1'b1 || bus.Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done: wa=%0d cnt=%0d full=%b af=%b ov=%b required 4 4 1 1 0",
                     bus.WriteAddr, bus.Count, bus.Full, bus.AlmostFull, bus.Overflow);
        end
        tick();
    endtask

    task automatic test_overflow();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.WrEn !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_wren: WrEn=%b required 0", bus.WrEn);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.Overflow !== m_ovf || bus.WriteAddr !== ptr_t'(m_wr)) begin
            n_fail++;
            $display("FAIL ovf_set: ov=%b wa=%0d required %b %0d", bus.Overflow, bus.WriteAddr,
                     m_ovf, m_wr);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: ov=%b required 0", bus.Overflow);
        end
        tick();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (bus.RdEn !== 1'b1 || bus.RdValid !== m_rdv) begin
                n_fail++;
                $display("FAIL drain_rd%0d: RdEn=%b RdValid=%b required 1 %b", i, bus.RdEn,
                         bus.RdValid, m_rdv);
            end
            n_checks++;
            if (bus.Count !== ptr_t'(m_q.size()) || bus.AlmostEmpty !== m_ae) begin
                n_fail++;
                $display("FAIL drain_cnt%0d: cnt=%0d ae=%b required %0d %b", i, bus.Count,
                         bus.AlmostEmpty, m_q.size(), m_ae);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.RdValid !== 1'b1 || bus.ReadAddr !== 3'b100 || bus.Empty !== 1'b1 ||
            bus.Count !== ptr_t'(0) || bus.AlmostEmpty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_done: rv=%b ra=%0d empty=%b cnt=%0d ae=%b required 1 4 1 0 1",
                     bus.RdValid, bus.ReadAddr, bus.Empty, bus.Count, bus.AlmostEmpty);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.RdValid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_rv_end: RdValid=%b required 0", bus.RdValid);
        end
        tick();
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.RdEn !== 1'b0) begin
            n_fail++;
            $display("FAIL udf_rden: RdEn=%b required 0", bus.RdEn);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.Underflow !== 1'b1 || bus.ReadAddr !== ptr_t'(m_rd)) begin
            n_fail++;
            $display("FAIL udf_set: un=%b ra=%0d required 1 %0d", bus.Underflow, bus.ReadAddr,
                     m_rd);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.Underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL udf_clr: un=%b required 0", bus.Underflow);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.WrEn !== 1'b0 || bus.RdEn !== 1'b1) begin
            n_fail++;
            $display("FAIL both_full_en: WrEn=%b RdEn=%b required 0 1", bus.WrEn, bus.RdEn);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.Count !== ptr_t'(3) || bus.Overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL both_full_res: cnt=%0d ov=%b required 3 1", bus.Count, bus.Overflow);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.WrEn !== 1'b1 || bus.RdEn !== 1'b0) begin
            n_fail++;
            $display("FAIL both_empty_en: WrEn=%b RdEn=%b required 1 0", bus.WrEn, bus.RdEn);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.Count !== ptr_t'(1) || bus.Underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL both_empty_res: cnt=%0d un=%b required 1 1", bus.Count, bus.Underflow);
        end
        tick();
    endtask

    task automatic test_random_wrap();
        int wraps = 0;
        for (int i = 0; i < 60; i++) begin
            logic wr, rd, clr;
            ptr_t prev_wa;
            wr  = ($urandom_range(0, 99) < 60);
            rd  = ($urandom_range(0, 99) < 50);
            clr = ($urandom_range(0, 9) == 0);
            drive(wr, rd, clr, 1'b0);
            n_checks++;
            if (bus.WrEn !== m_wren || bus.RdEn !== m_rden) begin
                n_fail++;
                $display("FAIL rnd_en%0d: WrEn=%b RdEn=%b required %b %b", i, bus.WrEn,
                         bus.RdEn, m_wren, m_rden);
            end
            n_checks++;
            if (bus.WriteAddr !== ptr_t'(m_wr) || bus.ReadAddr !== ptr_t'(m_rd) ||
                bus.Count !== ptr_t'(m_q.size())) begin
                n_fail++;
                $display("FAIL rnd_ptr%0d: wa=%0d ra=%0d cnt=%0d required %0d %0d %0d", i,
                         bus.WriteAddr, bus.ReadAddr, bus.Count, m_wr, m_rd, m_q.size());
            end
            n_checks++;
            if (bus.Count !== ptr_t'(bus.WriteAddr - bus.ReadAddr)) begin
                n_fail++;
                $display("FAIL rnd_invariant%0d: cnt=%0d wa-ra=%0d", i, bus.Count,
                         ptr_t'(bus.WriteAddr - bus.ReadAddr));
            end
            n_checks++;
            if ({bus.RdValid, bus.AlmostFull, bus.AlmostEmpty, bus.Overflow, bus.Underflow} !==
                {m_rdv, m_af, m_ae, m_ovf, m_udf}) begin
                n_fail++;
                $display("FAIL rnd_flags%0d: rv/af/ae/ov/un=%b%b%b%b%b required %b%b%b%b%b", i,
                         bus.RdValid, bus.AlmostFull, bus.AlmostEmpty, bus.Overflow,
                         bus.Underflow, m_rdv, m_af, m_ae, m_ovf, m_udf);
            end
            prev_wa = bus.WriteAddr;
            tick();
            if (prev_wa == 3'b111 && m_wr == 0) wraps++;
        end
        n_checks++;
        if (wraps < 1) begin
            n_fail++;
            $display("FAIL rnd_wrap: write pointer wraps=%0d required >=1", wraps);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.RdEn !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rden: RdEn=%b required 1", bus.RdEn);
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (bus.RdValid !== 1'b1 || bus.WrEn !== 1'b0 || bus.RdEn !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_inrst: rv=%b WrEn=%b RdEn=%b required 1 0 0", bus.RdValid,
                     bus.WrEn, bus.RdEn);
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.WriteAddr !== ptr_t'(0) || bus.ReadAddr !== ptr_t'(0) || bus.RdValid !== 1'b0 ||
            bus.AlmostEmpty !== 1'b1 || bus.Count !== ptr_t'(0)) begin
            n_fail++;
            $display("FAIL mid_after: wa=%0d ra=%0d rv=%b ae=%b cnt=%0d required 0 0 0 1 0",
                     bus.WriteAddr, bus.ReadAddr, bus.RdValid, bus.AlmostEmpty, bus.Count);
        end
        n_checks++;
        if (bus.WrEn !== 1'b1 || bus.RdEn !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_empty_en: WrEn=%b RdEn=%b required 1 0", bus.WrEn, bus.RdEn);
        end
        tick();
    endtask

    initial begin
        bus.WrReq  = 1'b0;
        bus.RdReq  = 1'b0;
        bus.ClrErr = 1'b0;
        rst        = 1'b1;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_simultaneous();
        test_random_wrap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
